tpu_instr_fetch: RTL and testbench

Instruction fetch/issue stage directly upstream of tpu_controller.
- Reads 32-bit instruction words from a synchronous-read instruction memory starting at a programmed base address.
- Buffers the words in a small FIFO and presents them to the controller's instr_data input with a valid/ready handshake.
- Stops fetching at a HALT opcode, drains the FIFO, then reports halted. Lets the controller stall on busy without losing words.

---
 rtl/tpu_isa_pkg.sv | 25 ++
 rtl/tpu_sync_fifo.sv | 54 +++++
 rtl/tpu_instr_fetch.sv | 105 ++++++++++
 tb/tb_tpu_instr_fetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions for the TPU front end: opcodes, instruction word layout, fetch states.
// No logic; no latency; no flow control.
// Imported by the fetch stage and anything else that decodes instruction words.
package tpu_isa_pkg;

    localparam logic [5:0] OPC_MATMUL = 6'h10;
    localparam logic [5:0] OPC_SYNC   = 6'h30;
    localparam logic [5:0] OPC_HALT   = 6'h3F;

    typedef struct packed {
        logic [5:0] opc;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [7:0] op_c;
        logic [1:0] flags;
    } instr_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FETCH,
        FS_DRAIN,
        FS_HALTED
    } fetch_state_t;

endpackage

// File: rtl/tpu_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; head word is 0 while empty.
// Latency: a write is visible at the head the cycle after it is written (no fall-through).
// Backpressure: rd_rdy holds the head; writes to a full FIFO are dropped unless a read frees a slot.
module tpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign rd_vld = (count != '0);
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && ((count != CNT_W'(DEPTH)) || do_rd);
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tpu_instr_fetch.sv
// Instruction fetch/issue: streams words from base_addr into a small buffer until a HALT opcode.
// Latency: start in cycle 0 -> imem_en in cycle 1 -> instr_valid in cycle 3; 1 word/cycle sustained.
// Backpressure: reads only issue while buffered + in-flight words fit, so instr_ready stalls lose nothing.
module tpu_instr_fetch #(
    parameter int         ADDR_W     = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [5:0] OPC_HALT   = tpu_isa_pkg::OPC_HALT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy,
    output logic              halted
);

    import tpu_isa_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state;
    logic             inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    instr_t           ret_word;
    logic             ret_live;
    logic             ret_halt;
    logic             ret_push;
    logic             room;

    // A return only matters while still fetching; anything else is a stale read.
    assign ret_word  = instr_t'(imem_rdata);
    assign ret_live  = inflight && (state == FS_FETCH);
    assign ret_halt  = ret_live && (ret_word.opc == OPC_HALT);
    assign ret_push  = ret_live && !ret_halt && !flush;

    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign room      = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

    // Suppressing the read in the HALT-return cycle leaves pc at HALT address + 1.
    assign imem_en   = !rst && !flush && (state == FS_FETCH) && !ret_halt && room;
    assign imem_addr = pc;

    assign fetch_busy = (state == FS_FETCH) || (state == FS_DRAIN);
    assign halted     = (state == FS_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_IDLE;
            pc       <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            state    <= FS_IDLE;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                pc <= pc + ADDR_W'(1);
            end
            case (state)
                FS_IDLE, FS_HALTED: begin
                    if (start) begin
                        state <= FS_FETCH;
                        pc    <= base_addr;
                    end
                end
                FS_FETCH: begin
                    if (ret_halt) begin
                        state <= FS_DRAIN;
                    end
                end
                FS_DRAIN: begin
                    if (fifo_count == '0) begin
                        state <= FS_HALTED;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    tpu_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .wr_vld (ret_push),
        .wr_dat (ret_word),
        .rd_vld (instr_valid),
        .rd_rdy (instr_ready),
        .rd_dat (instr_data),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_tpu_instr_fetch.sv
// Bench for tpu_instr_fetch: program-level model (expected word stream and read address sequence)
// checked every cycle, plus directed literal expectations per scenario.
module tb_tpu_instr_fetch;

    localparam int         AW       = 10;
    localparam int         DEPTH    = 4;
    localparam logic [5:0] HALT_OPC = 6'h3F;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          flush;
    logic          instr_ready;
    logic [AW-1:0] base_addr;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr_data;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          fetch_busy;
    logic          halted;

    logic [31:0] imem [1 << AW];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem[imem_addr];
    end

    tpu_instr_fetch #(
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .OPC_HALT   (HALT_OPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .flush       (flush),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .fetch_busy  (fetch_busy),
        .halted      (halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Program-level model: the words a program must deliver and the addresses it must read.
    logic [31:0]   exp_q [$];
    logic [AW-1:0] issue_log [$];
    logic [AW-1:0] exp_addr    = '0;
    logic          model_busy  = 1'b0;
    logic          issued_halt = 1'b0;
    int            nh_issues   = 0;
    int            pops        = 0;
    int            issues      = 0;
    logic          prev_stall  = 1'b0;
    logic [31:0]   prev_dat    = '0;

    function automatic bit is_halt(input logic [31:0] w);
        return w[31:26] == HALT_OPC;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        issue_log.delete();
        model_busy  = 1'b0;
        issued_halt = 1'b0;
        nh_issues   = 0;
        pops        = 0;
        issues      = 0;
    endtask

    task automatic model_start(input logic [AW-1:0] b);
        logic [AW-1:0] a;
        model_clear();
        model_busy = 1'b1;
        exp_addr   = b;
        a          = b;
        for (int i = 0; i < (1 << AW); i++) begin
            if (is_halt(imem[a])) break;
            exp_q.push_back(imem[a]);
            a++;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_clear();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_data", instr_data, prev_dat);
            end
            if (!instr_valid) chk("empty_data_zero", instr_data, 32'h0);
            if (imem_en) begin
                chk("issue_while_running", 32'(model_busy), 32'd1);
                chk("issue_after_halt", 32'(issued_halt), 32'd0);
                chk("issue_addr", 32'(imem_addr), 32'(exp_addr));
                issue_log.push_back(imem_addr);
                issues++;
                if (is_halt(imem[exp_addr])) issued_halt = 1'b1;
                else nh_issues++;
                exp_addr++;
            end
            if (instr_valid && instr_ready && !flush) begin
                chk("pop_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("word_order", instr_data, exp_q.pop_front());
                pops++;
            end
            if (model_busy) chk("occupancy_bound", 32'((nh_issues - pops) <= DEPTH), 32'd1);
            if (model_busy && issued_halt && exp_q.size() == 0) model_busy = 1'b0;
            prev_stall = instr_valid && !instr_ready && !flush;
            prev_dat   = instr_data;
            if (flush) model_clear();
            else if (start && !model_busy) model_start(base_addr);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        base_addr = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_halted(input string nm, input int max);
        int k = 0;
        while (!halted && k < max) begin
            tick();
            k++;
        end
        chk(nm, 32'(halted), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic saw_valid;
        rst = 1'b1; start = 1'b0; flush = 1'b0; instr_ready = 1'b0; base_addr = '0;
        for (int i = 0; i < (1 << AW); i++) imem[i] = 32'h0400_0000 | 32'(i);
        imem[10'h010] = 32'h4000_8010;
        imem[10'h011] = 32'hC00C_0004;
        imem[10'h012] = 32'h4001_8010;
        imem[10'h013] = 32'hFC00_0000;
        for (int i = 0; i < 16; i++) imem[10'h100 + i] = 32'h4000_0000 + 32'(i) * 32'h0001_1111;
        imem[10'h110] = 32'hFC00_0000;
        imem[10'h3FE] = 32'h4000_03FE;
        imem[10'h3FF] = 32'h4000_03FF;
        imem[10'h000] = 32'h4000_0000;
        imem[10'h001] = 32'hFC00_0001;
        for (int i = 0; i < 8; i++) imem[10'h200 + i] = 32'h4000_0200 + 32'(i);
        imem[10'h208] = 32'hFC00_0000;
        imem[10'h300] = 32'hFC00_0000;

        tick(3);
        rst = 1'b0;
        tick();
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", instr_data, 32'h0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);

        // Basic program, consumer always ready
        instr_ready = 1'b1;
        base_addr = 10'h010; start = 1'b1;
        chk("t1_en_c0", 32'(imem_en), 32'd0);
        tick(); start = 1'b0;
        chk("t1_en_c1", 32'(imem_en), 32'd1);
        chk("t1_addr_c1", 32'(imem_addr), 32'h010);
        chk("t1_valid_c1", 32'(instr_valid), 32'd0);
        tick(); chk("t1_valid_c2", 32'(instr_valid), 32'd0);
        tick(); chk("t1_valid_c3", 32'(instr_valid), 32'd1);
        chk("t1_data_c3", instr_data, 32'h4000_8010);
        tick(); chk("t1_data_c4", instr_data, 32'hC00C_0004);
        chk("t1_valid_c4", 32'(instr_valid), 32'd1);
        tick(); chk("t1_data_c5", instr_data, 32'h4001_8010);
        chk("t1_valid_c5", 32'(instr_valid), 32'd1);
        tick(); chk("t1_valid_c6", 32'(instr_valid), 32'd0);
        wait_halted("t1_halted", 20);
        chk("t1_pc", 32'(pc), 32'h014);
        chk("t1_busy", 32'(fetch_busy), 32'd0);
        chk("t1_pops", 32'(pops), 32'd3);

        // Restart from HALTED with the consumer stalled
        instr_ready = 1'b0;
        pulse_start(10'h010);
        chk("t2_halted_cleared", 32'(halted), 32'd0);
        tick(19);
        chk("t2_issues", 32'(issues), 32'd4);
        chk("t2_valid_held", 32'(instr_valid), 32'd1);
        chk("t2_data_held", instr_data, 32'h4000_8010);
        instr_ready = 1'b1;
        wait_halted("t2_halted", 30);
        chk("t2_pops", 32'(pops), 32'd3);
        chk("t2_pc", 32'(pc), 32'h014);

        // 16-word program, ready toggling every cycle
        instr_ready = 1'b0;
        pulse_start(10'h100);
        for (int k = 0; k < 200 && !halted; k++) begin
            instr_ready = ~instr_ready;
            tick();
        end
        instr_ready = 1'b1;
        chk("t3_halted", 32'(halted), 32'd1);
        chk("t3_pops", 32'(pops), 32'd16);
        chk("t3_pc", 32'(pc), 32'h111);

        // Address wrap at top of memory
        pulse_start(10'h3FE);
        wait_halted("t4_halted", 30);
        chk("t4_issue_count", 32'(issue_log.size()), 32'd4);
        if (issue_log.size() == 4) begin
            chk("t4_addr0", 32'(issue_log[0]), 32'h3FE);
            chk("t4_addr1", 32'(issue_log[1]), 32'h3FF);
            chk("t4_addr2", 32'(issue_log[2]), 32'h000);
            chk("t4_addr3", 32'(issue_log[3]), 32'h001);
        end
        chk("t4_pc", 32'(pc), 32'h002);
        chk("t4_pops", 32'(pops), 32'd3);

        // Flush with three words buffered and a read in flight
        instr_ready = 1'b0;
        pulse_start(10'h200);
        tick(4);
        chk("t5_head_before_flush", instr_data, 32'h4000_0200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_valid_after_flush", 32'(instr_valid), 32'd0);
        chk("t5_busy_after_flush", 32'(fetch_busy), 32'd0);
        chk("t5_halted_after_flush", 32'(halted), 32'd0);
        chk("t5_pc_after_flush", 32'(pc), 32'h204);
        tick(3);
        chk("t5_no_late_push", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        pulse_start(10'h200);
        chk("t5_refetch_en", 32'(imem_en), 32'd1);
        chk("t5_refetch_addr", 32'(imem_addr), 32'h200);
        wait_halted("t5_halted", 40);
        chk("t5_pops", 32'(pops), 32'd8);

        // start while fetching is ignored
        pulse_start(10'h010);
        tick();
        base_addr = 10'h300; start = 1'b1;
        chk("t6_pc_c2", 32'(pc), 32'h011);
        tick(); start = 1'b0;
        chk("t6_pc_c3", 32'(pc), 32'h012);
        chk("t6_busy", 32'(fetch_busy), 32'd1);
        wait_halted("t6_halted", 20);
        chk("t6_pops", 32'(pops), 32'd3);
        chk("t6_pc", 32'(pc), 32'h014);

        // HALT at base address
        saw_valid = 1'b0;
        pulse_start(10'h300);
        for (int k = 0; k < 20 && !halted; k++) begin
            if (instr_valid) saw_valid = 1'b1;
            tick();
        end
        chk("t7_halted", 32'(halted), 32'd1);
        chk("t7_no_valid", 32'(saw_valid), 32'd0);
        chk("t7_issues", 32'(issues), 32'd1);
        chk("t7_pc", 32'(pc), 32'h301);

        // Reset mid-program
        instr_ready = 1'b0;
        pulse_start(10'h100);
        tick(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t8_pc", 32'(pc), 32'd0);
        chk("t8_valid", 32'(instr_valid), 32'd0);
        chk("t8_busy", 32'(fetch_busy), 32'd0);
        chk("t8_imem_en", 32'(imem_en), 32'd0);
        chk("t8_halted", 32'(halted), 32'd0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
